// File: rtl/key_event_pkg.sv
// key_event_pkg: shared types and helpers for the key event block.
// Per-key FSM state encoding, counter width and a width helper for the tick counter.
package key_event_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DOWN = 2'd1,
    LONG = 2'd2
  } key_state_e;

  // Hold and repeat counters are 16 bits; LONG_MS/REPEAT_MS are limited to fit.
  localparam int HOLD_W = 16;

  // Number of bits needed to count 0..value-1, never less than 1.
  function automatic int clog2(input int value);
    int width;
    width = 1;
    while ((1 << width) < value) begin
      width = width + 1;
    end
    return width;
  endfunction

endpackage

// File: rtl/key_event_fsm.sv
// key_event_fsm: one key's two-flop synchroniser, IDLE/DOWN/LONG FSM and counters.
// The auto-repeat counter exists only when KEY_EVENT_REPEAT_EN is defined;
// otherwise repeat_o is tied low and LONG simply waits for release.
module key_event_fsm
  import key_event_pkg::*;
#(
  parameter int LONG_MS        = 1000,
  parameter int REPEAT_MS      = 200,
  parameter int KEY_ACTIVE_LOW = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic level_i,
  input  logic tick_i,
  output logic press_o,
  output logic release_o,
  output logic long_o,
  output logic repeat_o,
  output logic held_o
);

  localparam logic ACTIVE_LOW = (KEY_ACTIVE_LOW != 0);
  // The level that means "not pressed" is what the synchroniser resets to.
  localparam logic IDLE_LEVEL = ACTIVE_LOW;
  localparam logic [HOLD_W-1:0] LONG_LIMIT = HOLD_W'(LONG_MS);

  logic              sync1_q, sync1_d;
  logic              sync2_q, sync2_d;
  key_state_e        state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [HOLD_W-1:0] hold_inc;
  logic              press_q, press_d;
  logic              release_q, release_d;
  logic              long_q, long_d;
  logic              held_q, held_d;
  logic              pressed;

`ifdef KEY_EVENT_REPEAT_EN
  localparam logic [HOLD_W-1:0] REPEAT_LIMIT = HOLD_W'(REPEAT_MS);
  logic [HOLD_W-1:0] rep_q, rep_d;
  logic [HOLD_W-1:0] rep_inc;
  logic              repeat_q, repeat_d;
`else
  logic [HOLD_W-1:0] unused_repeat_ms;
  assign unused_repeat_ms = HOLD_W'(REPEAT_MS);
`endif

  assign pressed = sync2_q ^ ACTIVE_LOW;

  // Synchroniser shift, FSM transitions and one-cycle event pulses for this key.
  always_comb begin
    sync1_d   = level_i;
    sync2_d   = sync1_q;
    state_d   = state_q;
    hold_d    = hold_q;
    hold_inc  = hold_q + 1'b1;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
`ifdef KEY_EVENT_REPEAT_EN
    rep_d     = rep_q;
    rep_inc   = rep_q + 1'b1;
    repeat_d  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (pressed) begin
          state_d = DOWN;
          press_d = 1'b1;
          hold_d  = '0;
        end
      end
      DOWN: begin
        if (!pressed) begin
          state_d   = IDLE;
          release_d = 1'b1;
        end else if (tick_i) begin
          hold_d = hold_inc;
          if (hold_inc == LONG_LIMIT) begin
            state_d = LONG;
            long_d  = 1'b1;
`ifdef KEY_EVENT_REPEAT_EN
            rep_d   = '0;
`endif
          end
        end
      end
      LONG: begin
        if (!pressed) begin
          state_d   = IDLE;
          release_d = 1'b1;
        end
`ifdef KEY_EVENT_REPEAT_EN
        else if (tick_i) begin
          if (rep_inc == REPEAT_LIMIT) begin
            repeat_d = 1'b1;
            rep_d    = '0;
          end else begin
            rep_d = rep_inc;
          end
        end
`endif
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    held_d = (state_d != IDLE);
  end

  // State, counters and registered outputs; reset abandons any in-flight hold silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= IDLE_LEVEL;
      sync2_q   <= IDLE_LEVEL;
      state_q   <= IDLE;
      hold_q    <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      state_q   <= state_d;
      hold_q    <= hold_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      held_q    <= held_d;
    end
  end

`ifdef KEY_EVENT_REPEAT_EN
  // Repeat period counter and its pulse register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_q    <= '0;
      repeat_q <= 1'b0;
    end else begin
      rep_q    <= rep_d;
      repeat_q <= repeat_d;
    end
  end

  assign repeat_o = repeat_q;
`else
  assign repeat_o = 1'b0;
`endif

  assign press_o   = press_q;
  assign release_o = release_q;
  assign long_o    = long_q;
  assign held_o    = held_q;

endmodule

// File: rtl/key_event.sv
// key_event: turns debounced key levels into press/release/long/repeat pulses.
// Holds the shared free-running 1 ms tick generator and one key_event_fsm per key.
// Optional auto-repeat is enabled by defining KEY_EVENT_REPEAT_EN.
module key_event
  import key_event_pkg::*;
#(
  parameter int NUM_KEYS       = 2,
  parameter int CLK_PER_MS     = 50000,
  parameter int LONG_MS        = 1000,
  parameter int REPEAT_MS      = 200,
  parameter int KEY_ACTIVE_LOW = 1
) (
  input  logic                Sys_CLK,
  input  logic                Sys_RST_N,
  input  logic [NUM_KEYS-1:0] Key_Level,
  output logic [NUM_KEYS-1:0] Key_Press,
  output logic [NUM_KEYS-1:0] Key_Release,
  output logic [NUM_KEYS-1:0] Key_Long,
  output logic [NUM_KEYS-1:0] Key_Repeat,
  output logic [NUM_KEYS-1:0] Key_Held
);

  localparam int TICK_W = clog2(CLK_PER_MS);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLK_PER_MS - 1);

  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic              tick;

  // Tick fires on the last count of each millisecond and the counter wraps to 0.
  always_comb begin
    tick       = (tick_cnt_q == TICK_LAST);
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
  end

  // Free-running tick counter, never restarted by key activity.
  always_ff @(posedge Sys_CLK or negedge Sys_RST_N) begin
    if (!Sys_RST_N) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
    end
  end

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    key_event_fsm #(
      .LONG_MS       (LONG_MS),
      .REPEAT_MS     (REPEAT_MS),
      .KEY_ACTIVE_LOW(KEY_ACTIVE_LOW)
    ) u_fsm (
      .clk      (Sys_CLK),
      .rst_n    (Sys_RST_N),
      .level_i  (Key_Level[k]),
      .tick_i   (tick),
      .press_o  (Key_Press[k]),
      .release_o(Key_Release[k]),
      .long_o   (Key_Long[k]),
      .repeat_o (Key_Repeat[k]),
      .held_o   (Key_Held[k])
    );
  end

endmodule
